// File: rtl/reg_dump_pkg.sv
// Shared widths and FSM encoding for the register dump controller.
package reg_dump_pkg;
  localparam int W_DEF = 5;
  localparam int B_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND_A = 2'd2,
    SEND_B = 2'd3
  } state_t;
endpackage

// File: rtl/reg_dump_if.sv
// Bundle of the dump request, register-file read ports and output stream.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int B = B_DEF
) ();
  logic         start;
  logic [W-1:0] first_addr;
  logic [W-1:0] last_addr;
  logic [W-1:0] r_addr_A;
  logic [W-1:0] r_addr_B;
  logic [B-1:0] r_data_A;
  logic [B-1:0] r_data_B;
  // A beat transfers on a rising edge where out_valid and out_ready are both
  // high; once out_valid rises, data/addr/last hold until that edge.
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] out_data;
  logic [W-1:0] out_addr;
  logic         out_last;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  modport master (
    input  start, first_addr, last_addr, r_data_A, r_data_B, out_ready,
    output r_addr_A, r_addr_B, out_valid, out_data, out_addr, out_last,
           busy, done, dbg_state
  );

  modport slave (
    output start, first_addr, last_addr, r_data_A, r_data_B, out_ready,
    input  r_addr_A, r_addr_B, out_valid, out_data, out_addr, out_last,
           busy, done, dbg_state
  );
endinterface

// File: rtl/reg_dump_buf.sv
// Two-entry hold buffer capturing a register pair in a single FETCH cycle.
module reg_dump_buf
  import reg_dump_pkg::*;
#(
  parameter int B = B_DEF
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic [B-1:0] in_a,
  input  logic [B-1:0] in_b,
  output logic [B-1:0] hold_a,
  output logic [B-1:0] hold_b
);
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (load) begin
      hold_a <= in_a;
      hold_b <= in_b;
    end
  end
endmodule

// File: rtl/reg_file.sv
// Register file with one write port and two combinational read ports.
module reg_file
  import reg_dump_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int B = B_DEF
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr_A,
  input  logic [W-1:0] r_addr_B,
  output logic [B-1:0] r_data_A,
  output logic [B-1:0] r_data_B
);
  localparam int N = 1 << W;

  logic [B-1:0] regs [N];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (we) begin
      regs[w_addr] <= w_data;
    end
  end

  assign r_data_A = regs[r_addr_A];
  assign r_data_B = regs[r_addr_B];
endmodule

// File: rtl/reg_dump_ctrl.sv
// Streams registers first_addr..last_addr (wrapping) out of a dual-read-port
// register file, fetching two registers per FETCH cycle.
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int B = B_DEF
) (
  input logic        clk,
  input logic        n_reset,
  reg_dump_if.master bus
);
  state_t       state, state_nxt;
  logic [W-1:0] ptr, end_addr, ptr_p1;
  logic [B-1:0] hold_a, hold_b;
  logic         latch_start, advance, load_hold, done_set, done_q;
  logic [W-1:0] r_addr_a, r_addr_b, beat_addr;
  logic [B-1:0] beat_data;
  logic         beat_valid, beat_last;

  assign ptr_p1 = ptr + W'(1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      ptr      <= '0;
      end_addr <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_set;
      if (latch_start) begin
        ptr      <= bus.first_addr;
        end_addr <= bus.last_addr;
      end else if (advance) begin
        ptr <= ptr + W'(2);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    latch_start = 1'b0;
    advance     = 1'b0;
    load_hold   = 1'b0;
    done_set    = 1'b0;
    r_addr_a    = '0;
    r_addr_b    = '0;
    beat_valid  = 1'b0;
    beat_data   = '0;
    beat_addr   = '0;
    beat_last   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch_start = 1'b1;
          state_nxt   = FETCH;
        end
      end
      FETCH: begin
        r_addr_a  = ptr;
        r_addr_b  = ptr_p1;
        load_hold = 1'b1;
        state_nxt = SEND_A;
      end
      SEND_A: begin
        beat_valid = 1'b1;
        beat_data  = hold_a;
        beat_addr  = ptr;
        beat_last  = (ptr == end_addr);
        if (bus.out_ready) begin
          if (ptr == end_addr) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = SEND_B;
          end
        end
      end
      SEND_B: begin
        beat_valid = 1'b1;
        beat_data  = hold_b;
        beat_addr  = ptr_p1;
        beat_last  = (ptr_p1 == end_addr);
        if (bus.out_ready) begin
          if (ptr_p1 == end_addr) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  reg_dump_buf #(.B(B)) u_buf (
    .clk    (clk),
    .n_reset(n_reset),
    .load   (load_hold),
    .in_a   (bus.r_data_A),
    .in_b   (bus.r_data_B),
    .hold_a (hold_a),
    .hold_b (hold_b)
  );

  assign bus.r_addr_A  = r_addr_a;
  assign bus.r_addr_B  = r_addr_b;
  assign bus.out_valid = beat_valid;
  assign bus.out_data  = beat_data;
  assign bus.out_addr  = beat_addr;
  assign bus.out_last  = beat_last;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl driving a real reg_file; a queue-based model of
// the register contents predicts every beat of every dump.
module tb_reg_dump_ctrl;
  import reg_dump_pkg::*;

  localparam int W  = 5;
  localparam int B  = 32;
  localparam int N  = 1 << W;
  localparam int BW = 1 + W + B;

  typedef struct {
    logic [W-1:0] first;
    logic [W-1:0] last;
    int           ready_pct;
    int           exp_beats;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk        = 1'b0;
  logic n_reset    = 1'b0;
  logic rf_n_reset = 1'b0;
  always #5 clk = ~clk;

  logic         rf_we    = 1'b0;
  logic [W-1:0] rf_waddr = '0;
  logic [B-1:0] rf_wdata = '0;

  reg_dump_if #(.W(W), .B(B)) dif ();

  reg_dump_ctrl #(.W(W), .B(B)) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (dif)
  );

  reg_file #(.W(W), .B(B)) rf (
    .clk     (clk),
    .n_reset (rf_n_reset),
    .we      (rf_we),
    .w_addr  (rf_waddr),
    .w_data  (rf_wdata),
    .r_addr_A(dif.r_addr_A),
    .r_addr_B(dif.r_addr_B),
    .r_data_A(dif.r_data_A),
    .r_data_B(dif.r_data_B)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  logic [B-1:0]  model_regs [N];
  logic [BW-1:0] prev_beat  = '0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_cnt   = 0;
  int   beats_seen = 0;
  int   ready_pct  = 100;
  logic mon_en      = 1'b0;
  logic done_exp    = 1'b0;
  logic stall_prev  = 1'b0;
  logic rand_ready  = 1'b0;
  logic ready_force = 1'b0;

  vec_t         vecs [7];
  int           beats;
  int           exp_n;
  logic [W-1:0] f, l;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected beats of a dump: every address from f to l, wrapping mod N.
  function automatic void push_expected(input logic [W-1:0] fa, input logic [W-1:0] la);
    int           span_n;
    logic [W-1:0] a;
    span_n = ((int'(la) - int'(fa) + N) % N) + 1;
    for (int k = 0; k < span_n; k++) begin
      a = W'((int'(fa) + k) % N);
      exp_q.push_back({(k == span_n - 1), a, model_regs[a]});
    end
  endfunction

  // ---------------- ready driver (sole writer of out_ready) ----------------
  always @(posedge clk) begin
    #1;
    if (rand_ready) dif.out_ready = ($urandom_range(99) < ready_pct);
    else            dif.out_ready = ready_force;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("done", dif.done, done_exp);
      if (dif.done) done_cnt++;
      done_exp = 1'b0;
      if (stall_prev) begin
        check("valid_hold", dif.out_valid, 1);
        check("beat_stable", {dif.out_last, dif.out_addr, dif.out_data}, prev_beat);
      end
      stall_prev = dif.out_valid && !dif.out_ready;
      prev_beat  = {dif.out_last, dif.out_addr, dif.out_data};
      if (dif.out_valid && dif.out_ready) begin
        beats_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: actual addr %0d data %0h required no beat",
                   dif.out_addr, dif.out_data);
        end else begin
          logic [BW-1:0] e;
          e = exp_q.pop_front();
          if ({dif.out_last, dif.out_addr, dif.out_data} !== e) begin
            n_fail++;
            $display("FAIL beat: actual %0h required %0h (t=%0t)",
                     {dif.out_last, dif.out_addr, dif.out_data}, e, $time);
          end
          if (e[BW-1]) done_exp = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rf_write(input logic [W-1:0] a, input logic [B-1:0] d);
    @(posedge clk); #1;
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(posedge clk); #1;
    rf_we = 1'b0;
    model_regs[a] = d;
  endtask

  // Returns one time unit after the edge that samples start.
  task automatic start_dump(input logic [W-1:0] fa, input logic [W-1:0] la);
    @(posedge clk); #1;
    dif.start = 1'b1; dif.first_addr = fa; dif.last_addr = la;
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_within_budget", (done_cnt != d0), 1);
  endtask

  task automatic run_dump(input logic [W-1:0] fa, input logic [W-1:0] la,
                          input int pct, output int nbeats);
    int b0;
    push_expected(fa, la);
    ready_pct  = pct;
    rand_ready = 1'b1;
    b0 = beats_seen;
    start_dump(fa, la);
    wait_done(600);
    nbeats = beats_seen - b0;
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.start = 1'b0; dif.first_addr = '0; dif.last_addr = '0;
    for (int i = 0; i < N; i++) model_regs[i] = '0;

    vecs[0] = '{first: 5'd20, last: 5'd20, ready_pct: 100, exp_beats: 1};
    vecs[1] = '{first: 5'd30, last: 5'd1,  ready_pct: 100, exp_beats: 4};
    vecs[2] = '{first: 5'd1,  last: 5'd2,  ready_pct: 60,  exp_beats: 2};
    vecs[3] = '{first: 5'd0,  last: 5'd31, ready_pct: 80,  exp_beats: 32};
    vecs[4] = '{first: 5'd5,  last: 5'd4,  ready_pct: 100, exp_beats: 32};
    vecs[5] = '{first: 5'd31, last: 5'd0,  ready_pct: 50,  exp_beats: 2};
    vecs[6] = '{first: 5'd10, last: 5'd17, ready_pct: 40,  exp_beats: 8};

    repeat (3) @(posedge clk);
    #1 rf_n_reset = 1'b1;
    check("rst_valid", dif.out_valid, 0);
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_raddr", {dif.r_addr_A, dif.r_addr_B}, 0);
    check("rst_beat", {dif.out_last, dif.out_addr, dif.out_data}, 0);
    check("rst_state", dif.dbg_state, IDLE);
    @(posedge clk); #1;
    n_reset = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < N; i++) rf_write(W'(i), $urandom);

    // Two-beat dump: latency and back-to-back throughput.
    rf_write(5'd1, 32'd15);
    rf_write(5'd2, 32'd25);
    ready_force = 1'b1;
    push_expected(5'd1, 5'd2);
    start_dump(5'd1, 5'd2);
    check("fetch_valid", dif.out_valid, 0);
    check("fetch_busy", dif.busy, 1);
    check("fetch_raddr_a", dif.r_addr_A, 1);
    check("fetch_raddr_b", dif.r_addr_B, 2);
    @(posedge clk); #1;
    check("beat1_valid", dif.out_valid, 1);
    check("beat1", {dif.out_last, dif.out_addr, dif.out_data}, {1'b0, 5'd1, 32'd15});
    @(posedge clk); #1;
    check("beat2_valid", dif.out_valid, 1);
    check("beat2", {dif.out_last, dif.out_addr, dif.out_data}, {1'b1, 5'd2, 32'd25});
    @(posedge clk); #1;
    check("after_valid", dif.out_valid, 0);
    check("after_done", dif.done, 1);
    check("after_busy", dif.busy, 0);
    @(posedge clk); #1;
    check("done_pulse_end", dif.done, 0);
    check("idle_raddr", {dif.r_addr_A, dif.r_addr_B}, 0);

    // Backpressure for three cycles; start raised mid-dump must be ignored.
    rf_write(5'd20, 32'd100);
    rf_write(5'd21, 32'd200);
    ready_force = 1'b0;
    push_expected(5'd20, 5'd21);
    start_dump(5'd20, 5'd21);
    @(posedge clk); #1;
    dif.start = 1'b1; dif.first_addr = 5'd3; dif.last_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", dif.out_valid, 1);
      check("stall_data", dif.out_data, 100);
      if (i < 2) begin
        @(posedge clk); #1;
        dif.start = 1'b0;
      end
    end
    #2 ready_force = 1'b1;
    wait_done(20);
    check("stall_queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("ignored_start_busy", dif.busy, 0);
    check("ignored_start_valid", dif.out_valid, 0);

    // Table-driven dumps, including single-beat and wrapping ranges.
    for (int i = 0; i < 7; i++) begin
      run_dump(vecs[i].first, vecs[i].last, vecs[i].ready_pct, beats);
      check($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
    end

    // Random ranges, contents and backpressure.
    for (int i = 0; i < 20; i++) begin
      f = W'($urandom_range(N - 1));
      l = W'(int'(f) + int'($urandom_range(11)));
      if ($urandom_range(1) == 1) rf_write(W'($urandom_range(N - 1)), $urandom);
      exp_n = ((int'(l) - int'(f) + N) % N) + 1;
      run_dump(f, l, int'($urandom_range(30, 100)), beats);
      check("rand_beats", beats, exp_n);
    end

    // Reset while in SEND_B, then a clean dump afterwards.
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    mon_en      = 1'b0;
    start_dump(5'd1, 5'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_state", dif.dbg_state, SEND_B);
    #2 n_reset = 1'b0;
    #1;
    check("reset_valid", dif.out_valid, 0);
    check("reset_busy", dif.busy, 0);
    check("reset_done", dif.done, 0);
    check("reset_state", dif.dbg_state, IDLE);
    check("reset_raddr", {dif.r_addr_A, dif.r_addr_B}, 0);
    @(posedge clk); #1;
    dif.start = 1'b1; dif.first_addr = 5'd7; dif.last_addr = 5'd9;
    @(posedge clk); #1;
    dif.start = 1'b0;
    check("in_reset_busy", dif.busy, 0);
    n_reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", dif.busy, 0);
    check("post_reset_valid", dif.out_valid, 0);
    exp_q.delete();
    done_exp   = 1'b0;
    stall_prev = 1'b0;
    mon_en     = 1'b1;
    run_dump(5'd4, 5'd6, 100, beats);
    check("post_reset_beats", beats, 3);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
